// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable program memory, program counter and a small
// prefetch FIFO feeding the 16-bit core one instruction per accepted handshake.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [15:0]           load_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic                  flush,
  output logic [15:0]           instr_out,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  busy,
  output logic                  halted,
  output logic [1:0]            dbg_state_o
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_e;

  state_e                  state_q;
  logic [15:0]             mem_q [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [15:0]             rd_data_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_valid_q;
  logic [15:0]             fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic mem_we;
  logic fifo_empty;
  logic pop;
  logic ret_halt;
  logic push;
  logic issue;
  logic last_pop;

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready
  // and flush is low; while instr_valid=1 and instr_ready=0 the outputs hold.
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && instr_ready && !flush;
  assign last_pop   = (count_q == ONE_C) && pop;
  assign ret_halt   = (state_q == FETCH) && rd_valid_q && (rd_data_q[15:12] == 4'hF);
  assign push       = (state_q == FETCH) && rd_valid_q && !ret_halt && !flush;
  // A read is issued only if its word is guaranteed a FIFO slot on return.
  assign issue      = (state_q == FETCH) && !flush && !ret_halt &&
                      ((count_q + {{PTR_W{1'b0}}, rd_valid_q}) < DEPTH_C);
  assign mem_we     = load_en && (state_q == IDLE);

  // Memory, read data and FIFO storage carry no reset; program contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[load_addr] <= load_data;
    if (issue) begin
      rd_data_q <= mem_q[pc_q];
      rd_addr_q <= pc_q;
    end
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= rd_data_q;
      fifo_pc_q[wr_ptr_q]    <= rd_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rd_valid_q <= issue;
      if (issue) pc_q <= pc_q + ADDR_WIDTH'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q <= FETCH;
            pc_q    <= start_pc;
          end
        end
        FETCH: begin
          if (ret_halt) state_q <= (fifo_empty || last_pop) ? HALTED : DRAIN;
        end
        DRAIN: begin
          if (fifo_empty || last_pop) state_q <= HALTED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_valid = !fifo_empty;
  assign instr_out   = fifo_empty ? 16'h0000 : fifo_instr_q[rd_ptr_q];
  assign pc_out      = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);
  assign halted      = (state_q == HALTED);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a program-walking reference model fills an expected
// queue at each start; a negedge monitor pops and compares every accepted word.
module tb_instr_fetch_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          flush = 1'b0;
  logic          instr_ready = 1'b0;
  logic [15:0]   instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          halted;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pop_cyc = -1;
  int halt_cyc = 0;
  int rel_cyc = 0;

  logic [15:0]      ref_mem [256];
  logic [AW+15:0]   exp_q [$];
  logic             prev_stall = 1'b0;
  logic [15:0]      prev_instr = '0;
  logic [AW-1:0]    prev_pc = '0;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_pc(start_pc), .flush(flush),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .busy(busy), .halted(halted), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: walk memory from pc until a HALT opcode
  function automatic void push_expected(input logic [AW-1:0] pc);
    logic [AW-1:0] a;
    a = pc;
    for (int i = 0; i < 256; i++) begin
      if (ref_mem[a][15:12] == 4'hF) break;
      exp_q.push_back({a, ref_mem[a]});
      a = a + 1'b1;
    end
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", instr_valid, 1);
        check("hold_instr", instr_out, prev_instr);
        check("hold_pc", pc_out, prev_pc);
      end
      if (instr_valid && instr_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h at pc %0h expected none", instr_out, pc_out);
        end else begin
          e = exp_q.pop_front();
          check("instr_out", instr_out, e[15:0]);
          check("pc_out", pc_out, e[AW+15:16]);
        end
        last_pop_cyc = cyc;
      end else if (!instr_valid) begin
        check("idle_instr_zero", instr_out, 0);
        check("idle_pc_zero", pc_out, 0);
      end
      prev_stall = instr_valid && !instr_ready && !flush;
      prev_instr = instr_out;
      prev_pc    = pc_out;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    pulse_load(a, d);
    ref_mem[a] = d;
  endtask

  task automatic do_start(input logic [AW-1:0] pc);
    start = 1'b1; start_pc = pc;
    push_expected(pc);
    tick();
    start = 1'b0;
  endtask

  task automatic do_start_load(input logic [AW-1:0] pc, input logic [15:0] d);
    load_en = 1'b1; load_addr = pc; load_data = d;
    ref_mem[pc] = d;
    do_start(pc);
    load_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", instr_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_halted", halted, 0);
    tick();
  endtask

  task automatic wait_halt(input int budget, input bit rnd, output int hc);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (halted || n >= budget) break;
      tick();
      n++;
      if (rnd) instr_ready = ($urandom_range(0, 2) != 0);
    end
    hc = cyc;
    check("halt_reached", halted, 1);
    check("halt_after_last_pop", cyc, last_pop_cyc + 1);
    check("halt_busy_low", busy, 0);
    check("halt_queue_empty", exp_q.size(), 0);
    check("halt_valid_low", instr_valid, 0);
    tick();
  endtask

  initial begin
    logic [AW-1:0] base;
    int            len;
    logic [3:0]    op;
    logic [11:0]   lo;
    logic [15:0]   w0;

    // reset values
    @(negedge clk);
    check("rst_instr", instr_out, 16'h0000);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    @(posedge clk); #2; rst = 1'b1;
    tick();

    // basic program, ready high, latency and halt timing
    load_word(8'd0, 16'h1250);
    load_word(8'd1, 16'h2250);
    load_word(8'd2, 16'h3250);
    load_word(8'd3, 16'hF000);
    instr_ready = 1'b1;
    do_start(8'd0);
    @(negedge clk);
    check("lat_c1_valid", instr_valid, 0);
    check("lat_c1_busy", busy, 1);
    @(negedge clk);
    check("lat_c2_valid", instr_valid, 0);
    @(negedge clk);
    check("lat_c3_valid", instr_valid, 1);
    wait_halt(50, 1'b0, halt_cyc);
    do_flush();

    // stall for 10+ cycles then release: back-to-back delivery
    instr_ready = 1'b0;
    do_start(8'd0);
    repeat (12) @(negedge clk);
    check("stall_valid", instr_valid, 1);
    check("stall_instr", instr_out, 16'h1250);
    check("stall_pc", pc_out, 0);
    check("stall_busy", busy, 1);
    tick();
    instr_ready = 1'b1;
    rel_cyc = cyc;
    wait_halt(50, 1'b0, halt_cyc);
    check("release_back_to_back", halt_cyc, rel_cyc + 3);
    do_flush();

    // wrap-around at the top of memory
    load_word(8'd254, 16'h4250);
    load_word(8'd255, 16'h5250);
    load_word(8'd0, 16'hF000);
    do_start(8'd254);
    wait_halt(50, 1'b0, halt_cyc);
    do_flush();

    // flush together with start mid-stream
    load_word(8'd0, 16'h1250);
    do_start(8'd0);
    repeat (4) tick();
    flush = 1'b1; start = 1'b1; start_pc = 8'd1;
    tick();
    flush = 1'b0; start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("fs_valid", instr_valid, 0);
    check("fs_busy", busy, 0);
    check("fs_halted", halted, 0);
    repeat (3) @(negedge clk);
    check("fs_start_ignored", busy, 0);
    tick();
    do_start(8'd2);
    wait_halt(50, 1'b0, halt_cyc);
    do_flush();

    // asynchronous reset while the FIFO holds three entries
    instr_ready = 1'b0;
    do_start(8'd0);
    repeat (10) tick();
    #2; rst = 1'b0; #1;
    check("arst_instr", instr_out, 16'h0000);
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc_out, 0);
    check("arst_busy", busy, 0);
    check("arst_halted", halted, 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    tick();
    instr_ready = 1'b1;
    do_start(8'd0);
    wait_halt(50, 1'b0, halt_cyc);
    do_flush();

    // writes while busy or halted must be ignored
    instr_ready = 1'b0;
    do_start(8'd0);
    tick();
    pulse_load(8'd1, 16'hABCD);
    repeat (8) tick();
    pulse_load(8'd2, 16'h9999);
    instr_ready = 1'b1;
    wait_halt(50, 1'b0, halt_cyc);
    pulse_load(8'd0, 16'h7777);
    do_flush();
    do_start(8'd0);
    wait_halt(50, 1'b0, halt_cyc);
    do_flush();

    // randomized programs, load+start in the same cycle, random ready
    for (int it = 0; it < 8; it++) begin
      base = AW'($urandom_range(0, 255));
      len  = $urandom_range(1, 12);
      for (int k = 1; k < len; k++) begin
        op = 4'($urandom_range(0, 14));
        lo = 12'($urandom);
        load_word(base + AW'(k), {op, lo});
      end
      lo = 12'($urandom);
      load_word(base + AW'(len), {4'hF, lo});
      op = 4'($urandom_range(0, 14));
      lo = 12'($urandom);
      w0 = {op, lo};
      do_start_load(base, w0);
      wait_halt(400, 1'b1, halt_cyc);
      instr_ready = 1'b1;
      do_flush();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the 16-bit processor core and drives its `instruction` input. It holds a loadable program memory, a program counter, and a small prefetch FIFO. It presents one instruction per accepted handshake and stops at a HALT opcode. While no instruction is valid, it drives 16'h0000 (opcode 0000), which the core's control unit decodes as "no register write".

## Interface
- ADDR_WIDTH, 8, program-memory address width; memory depth is 2**ADDR_WIDTH words of 16 bits.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state except the memory array.
- load_en  in  1  program-memory write strobe; honoured only in IDLE.
- load_addr  in  ADDR_WIDTH  program-memory write address.
- load_data  in  16  program-memory write data.
- start  in  1  one-cycle pulse; begin fetching at start_pc; honoured only in IDLE or HALTED.
- start_pc  in  ADDR_WIDTH  first fetch address.
- flush  in  1  abort; empties the FIFO, discards the in-flight read, returns to IDLE.
- instr_out  out  16  FIFO head when instr_valid=1, else 16'h0000.
- instr_valid  out  1  instr_out holds a fetched instruction.
- instr_ready  in  1  consumer accepts instr_out this cycle.
- pc_out  out  ADDR_WIDTH  address of the instruction currently on instr_out; 0 when not valid.
- busy  out  1  high in FETCH and DRAIN.
- halted  out  1  high in HALTED.

## Operation
- Memory: synchronous write; synchronous read with 1-cycle latency, one read per cycle maximum.
- FSM states: IDLE, FETCH, DRAIN, HALTED. Reset state is IDLE.
- IDLE: load_en writes memory. start loads pc with start_pc and moves to FETCH.
- FETCH: a read of pc is issued in a cycle only when fifo_count + inflight + push_this_cycle < FIFO_DEPTH. Each issued read increments pc modulo 2**ADDR_WIDTH; address 2**ADDR_WIDTH-1 wraps to 0.
- Returned read data with opcode [15:12] = 4'b1111 (HALT) is not pushed to the FIFO. Issuing stops, and the FSM moves to DRAIN. Any read already issued behind the HALT is discarded.
- All other returned words are pushed to the FIFO together with their address.
- DRAIN: no reads are issued. When the FIFO is empty and no pop is pending, the FSM moves to HALTED.
- HALTED: behaves like IDLE for start. load_en is ignored.
- Handshake: a pop occurs when instr_valid && instr_ready. instr_out and pc_out hold steady while instr_valid=1 and instr_ready=0.
- flush, in any state: FIFO count goes to 0, the in-flight read is dropped, and the FSM moves to IDLE next cycle. flush takes priority over start and over the handshake.
- load_en together with start in IDLE: the write completes, and fetch starts in the same cycle. A read of that address issued on the next cycle returns the new data.
- Reset mid-operation clears the FIFO, pc, and FSM. Memory contents are retained.
- Reset values: instr_out=16'h0000, instr_valid=0, pc_out=0, busy=0, halted=0.

## Timing
- start sampled at edge E0 → read of start_pc issued during the cycle after E0 → data captured at E2 → instr_valid=1 after E2. Start-to-valid latency is 2 cycles.
- Steady state with instr_ready held high: one instruction per cycle, with no bubbles.
- instr_ready low: the FIFO fills to FIFO_DEPTH and issuing pauses, so there is no overflow and no lost word.
- instr_ready returning high: throughput is back to 1 per cycle within 1 cycle.
- HALT returned at edge En → busy stays high until the last FIFO entry is popped → halted=1 one cycle after that pop.
- If the FIFO is already empty when HALT returns, halted=1 at En+1.
- flush sampled at edge Ef → instr_valid=0 and busy=0 after Ef.

## Test plan
- Load mem[0..3] = 16'h1250, 16'h2250, 16'h3250, 16'hF000; start, start_pc=0; instr_ready=1 → instr_out sequence 1250, 2250, 3250 with pc_out 0, 1, 2 on consecutive cycles, first valid 2 cycles after start. HALT is never presented; halted=1 the cycle after the 3250 pop.
- Same program with instr_ready=0 for 10 cycles → instr_valid=1, instr_out holds 1250, and pc_out holds 0. Release → 2250 and 3250 follow back-to-back, and no word is duplicated or dropped.
- ADDR_WIDTH=8; mem[254]=16'h4250, mem[255]=16'h5250, mem[0]=16'hF000; start_pc=254 → 4250 (pc 254), then 5250 (pc 255), then halted. This checks wrap-around.
- Mid-stream flush, asserted with start in the same cycle → valid drops the next cycle, the FSM is in IDLE, and the start is ignored. A following start at pc=2 delivers 3250 first.
- rst driven low asynchronously while the FIFO holds 3 entries → all outputs take their reset values immediately. After release and start at 0, the program re-executes from 1250, showing memory was retained.
- load_en pulsed while busy → memory is unchanged, checked by re-fetch after halt.
